ifu_fetch: RTL
==============

# ifu_fetch

Instruction fetch unit for the NPC core. It holds the architectural PC and issues word fetches to instruction memory over a request/response port. It presents each fetched instruction with its PC to the decode stage over a valid/ready handshake; decode slices `opcode[6:2]` and `inst[31:7]` from it for immediate generation. A redirect input from execute (jumps, taken branches) discards any stale fetch and restarts at the target.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: PC loaded on reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_addr` out 32: fetch address; equals the current PC.
- `imem_resp_valid` in 1: read data valid. The response is always accepted; there is no resp-ready.
- `imem_rdata` in 32: instruction word.
- `inst_valid` out 1: instruction available to decode.
- `inst_ready` in 1: decode accepts the instruction.
- `inst` out 32: instruction word.
- `inst_pc` out 32: PC of `inst`.
- `inst_misalign` out 1: the delivered slot is an instruction-address-misaligned fault (see Configuration).
- `redirect_valid` in 1: execute requests a PC change.
- `redirect_pc` in 32: redirect target.

## Operation
- FSM states: REQ, WAIT, HOLD.
  - REQ: `imem_req_valid`=1. Go to WAIT when `imem_req_ready`=1.
  - WAIT: wait for `imem_resp_valid`. On response, capture `imem_rdata` into the output register and go to HOLD.
  - HOLD: `inst_valid`=1. When `inst_ready`=1, set PC to PC+4 and go to REQ.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0, with no flag.
- Redirect behaviour, which has priority over every other event in the same cycle:
  - In REQ: PC is set to the target. If the request handshakes in that same cycle, that request is marked as to-drop.
  - In WAIT: set the drop flag and latch the target. When the response arrives it is discarded, not delivered; go to REQ with the target.
  - If `imem_resp_valid` coincides with the redirect, that response is discarded. Go straight to REQ with the target.
  - In HOLD: the held instruction is discarded, even if `inst_ready`=1 in the same cycle; no PC+4. Go to REQ with the target.
  - Repeated redirects while a drop is pending: the last target wins, and only one response is dropped.
- The output register (`inst`, `inst_pc`, `inst_misalign`) is stable while `inst_valid`=1 and `inst_ready`=0.
- Only one outstanding memory request at a time.

## Timing
- Reset values:
  - state=REQ, PC=`RESET_PC`, drop flag=0.
  - `imem_req_valid`=1 in the first cycle after `rst` deasserts; it is 0 while `rst`=1.
  - `inst_valid`=0, `inst`=0, `inst_pc`=0, `inst_misalign`=0.
- `rst` asserted mid-operation: immediate return to the reset state. Any response arriving after reset that belongs to a pre-reset request is ignored, by clearing WAIT.
- With memory `imem_req_ready`=1 and response one cycle later:
  - request accepted in cycle t;
  - `imem_resp_valid` in t+1;
  - `inst_valid` in t+2;
  - with `inst_ready`=1, the next request is issued in t+3.
  - Steady throughput: 1 instruction per 3 cycles.
- Redirect in any state: the request to the target appears no later than the following cycle, except when it occurs in WAIT, where the request waits for the pending response.
- `imem_addr`, `imem_req_valid`, `inst_valid` and `inst_ready`-dependent transitions are registered state decodes. There is no combinational path from `inst_ready` to `imem_req_valid`.

## Configuration
- Macro: `IFU_ALIGN_CHECK_EN`.
- Defined:
  - A redirect target with `redirect_pc[1:0]`≠0 issues no memory request.
  - The FSM goes directly to HOLD with `inst`=32'h0000_0000, `inst_pc`=target, `inst_misalign`=1.
  - On handshake, the FSM stays in REQ-wait with no auto-increment until the next redirect: `imem_req_valid`=0.
- Undefined:
  - The target is forced to `{redirect_pc[31:2],2'b00}`.
  - `inst_misalign` is tied to 0.

## Test plan
- Reset release, memory with ready=1 and 1-cycle response returning 32'h00000093 → first `imem_addr`=32'h8000_0000; `inst`=32'h00000093 and `inst_pc`=32'h8000_0000 two cycles after request accept; next `imem_addr`=32'h8000_0004.
- Decode stall: `inst_ready`=0 for 5 cycles with a held instruction → `inst`/`inst_pc` unchanged, `imem_req_valid`=0 throughout, PC advances only after ready.
- Redirect to 32'h8000_0100 during WAIT, with memory response 32'hDEADBEEF 3 cycles later → that word is never presented. The next request address is 32'h8000_0100.
- Redirect coinciding with `inst_valid`&`inst_ready` at PC 32'h8000_0010, target 32'h8000_0040 → no fetch of 32'h8000_0014. The next `imem_addr`=32'h8000_0040.
- `rst` pulsed while in WAIT, then a stale response arrives → it is ignored. The first post-reset `imem_addr`=`RESET_PC`, and `inst_valid` stays 0 until the new response.
- Redirect to 32'h8000_0102:
  - with the macro: `inst_valid`=1, `inst_misalign`=1, `inst_pc`=32'h8000_0102, no memory request;
  - without it: `imem_addr`=32'h8000_0100.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: bundles the instruction-memory request/response port, the
// decode-side valid/ready port and the execute redirect into one interface.
//   master : the fetch unit (drives imem request, instruction to decode)
//   slave  : the environment (memory, decode, execute)
interface ifu_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_misalign;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_misalign,
        input  imem_req_ready, imem_resp_valid, imem_rdata, inst_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_misalign,
        output imem_req_ready, imem_resp_valid, imem_rdata, inst_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit. Holds the PC, issues one word fetch at a
// time to instruction memory and hands each fetched word plus its PC to decode.
// A redirect from execute discards any stale fetch and restarts at the target.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - ifu_fetch_if.master: imem request/response, decode valid/ready,
//          redirect from execute
//
// Optional feature macro IFU_ALIGN_CHECK_EN: when defined, a redirect to a
// non-word-aligned target produces an instruction-address-misaligned slot
// instead of a memory request. When undefined, targets are forced to word
// alignment and inst_misalign is always 0.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input logic         clk,
    input logic         rst,
    ifu_fetch_if.master bus
);
    // PARK is only reachable with the alignment check: after a misaligned slot
    // is consumed, fetch idles until the next redirect.
    typedef enum logic [1:0] {REQ, WAIT, HOLD, PARK} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        drop, drop_n;
    logic [31:0] inst_q, inst_n;
    logic [31:0] ipc_q, ipc_n;
    logic        mis_q, mis_n;

    logic [31:0] target;
    logic        go;
    logic [31:0] go_addr;
    logic        go_bad;

`ifdef IFU_ALIGN_CHECK_EN
    assign target = bus.redirect_pc;
`else
    assign target = bus.redirect_pc & ~32'h0000_0003;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= REQ;
            pc     <= RESET_PC;
            drop   <= 1'b0;
            inst_q <= '0;
            ipc_q  <= '0;
            mis_q  <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            drop   <= drop_n;
            inst_q <= inst_n;
            ipc_q  <= ipc_n;
            mis_q  <= mis_n;
        end
    end

    // "go" means: restart fetching at go_addr (either a new redirect target or
    // the target latched while a dropped response was still outstanding).
    always_comb begin
        state_n = state;
        pc_n    = pc;
        drop_n  = drop;
        inst_n  = inst_q;
        ipc_n   = ipc_q;
        mis_n   = mis_q;
        go      = 1'b0;
        go_addr = pc;
        go_bad  = 1'b0;

        case (state)
            REQ: begin
                if (bus.redirect_valid) begin
                    if (bus.imem_req_ready) begin
                        // The old-PC request was accepted this cycle; its
                        // response must be swallowed before restarting.
                        state_n = WAIT;
                        drop_n  = 1'b1;
                        pc_n    = target;
                    end else begin
                        go      = 1'b1;
                        go_addr = target;
                    end
                end else if (bus.imem_req_ready) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_resp_valid) begin
                    if (bus.redirect_valid) begin
                        go      = 1'b1;
                        go_addr = target;
                        drop_n  = 1'b0;
                    end else if (drop) begin
                        go      = 1'b1;
                        go_addr = pc;
                        drop_n  = 1'b0;
                    end else begin
                        inst_n  = bus.imem_rdata;
                        ipc_n   = pc;
                        mis_n   = 1'b0;
                        state_n = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    // Last target wins; still only one response to drop.
                    drop_n = 1'b1;
                    pc_n   = target;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    go      = 1'b1;
                    go_addr = target;
                end else if (bus.inst_ready) begin
                    if (mis_q) begin
                        state_n = PARK;
                    end else begin
                        pc_n    = pc + 32'd4;
                        state_n = REQ;
                    end
                end
            end
            PARK: begin
                if (bus.redirect_valid) begin
                    go      = 1'b1;
                    go_addr = target;
                end
            end
            default: state_n = REQ;
        endcase

`ifdef IFU_ALIGN_CHECK_EN
        go_bad = |go_addr[1:0];
`endif

        if (go) begin
            pc_n = go_addr;
            if (go_bad) begin
                state_n = HOLD;
                inst_n  = '0;
                ipc_n   = go_addr;
                mis_n   = 1'b1;
            end else begin
                state_n = REQ;
            end
        end
    end

    assign bus.imem_req_valid = (state == REQ) && !rst;
    assign bus.imem_addr      = pc;
    assign bus.inst_valid     = (state == HOLD);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = ipc_q;
`ifdef IFU_ALIGN_CHECK_EN
    assign bus.inst_misalign  = mis_q;
`else
    assign bus.inst_misalign  = 1'b0;
`endif
endmodule
